pwm_ramp_ctrl: RTL and testbench

Soft-start/soft-stop sequencer for the 5-step PWM block. It accepts a target duty level from a requester over a valid/ready handshake. It then walks the PWM's E/X/Y controls one level at a time toward that target, changing only at PWM period boundaries, with a programmable dwell between steps. A fault input forces the PWM off immediately and holds it off until the fault clears.

---
 rtl/pwm_ctrl_pkg.sv | 23 ++
 rtl/pwm_level_enc.sv | 25 ++
 rtl/pwm_ramp_ctrl.sv | 133 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for PWM configurators: level codes, sequencer states and
// request clamping.
package pwm_ctrl_pkg;

   localparam logic [2:0] LVL_OFF = 3'd0;
   localparam logic [2:0] LVL_25  = 3'd1;
   localparam logic [2:0] LVL_50  = 3'd2;
   localparam logic [2:0] LVL_75  = 3'd3;
   localparam logic [2:0] LVL_100 = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP_UP = 2'd1,
      RAMP_DN = 2'd2,
      FAULT   = 2'd3
   } state_t;

   // Requests above full duty saturate at full duty.
   function automatic logic [2:0] clamp_level(input logic [2:0] lvl);
      return (lvl > LVL_100) ? LVL_100 : lvl;
   endfunction

endpackage

// File: rtl/pwm_level_enc.sv
// Combinational decode of a duty level into the 5-step PWM's E/X/Y controls.
// Out-of-range codes decode as full duty.
module pwm_level_enc
   import pwm_ctrl_pkg::*;
(
   input  logic [2:0] level,
   output logic       e,
   output logic       x,
   output logic       y
);

   logic [1:0] sel;

   always_comb begin
      e   = 1'b0;
      sel = 2'b00;
      if (level != LVL_OFF) begin
         e   = 1'b1;
         sel = (level >= LVL_100) ? 2'b11 : 2'(level - 3'd1);
      end
   end

   assign {x, y} = sel;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: steps the PWM duty one level per dwell
// interval toward a requested target, aligned to PWM period boundaries.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int DWELL   = 4
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_level,
   output logic       req_ready,
   input  logic       fault,
   output logic       E,
   output logic       X,
   output logic       Y,
   output logic [2:0] level,
   output logic       busy,
   output logic       done
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [DWELL_W-1:0] DWELL_INC  = DWELL_W'(1);

   state_t             state_reg, state_next;
   logic [1:0]         phase_reg;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic               first_reg, first_next;
   logic [2:0]         target_reg, target_next;
   logic [2:0]         level_reg, level_next;
   logic               done_reg, done_next;
   logic               e_reg, x_reg, y_reg;
   logic               e_next, x_next, y_next;
   logic [2:0]         req_target, level_step;
   logic               period_end;

   assign period_end = (phase_reg == 2'd3);
   assign req_target = clamp_level(req_level);
   assign level_step = (state_reg == RAMP_UP) ? level_reg + 3'd1 : level_reg - 3'd1;

   always_comb begin
      state_next  = state_reg;
      dwell_next  = dwell_reg;
      first_next  = first_reg;
      target_next = target_reg;
      level_next  = level_reg;
      done_next   = 1'b0;
      if (fault) begin
         state_next  = FAULT;
         level_next  = LVL_OFF;
         target_next = LVL_OFF;
         dwell_next  = '0;
         first_next  = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  target_next = req_target;
                  dwell_next  = '0;
                  first_next  = 1'b1;
                  if (req_target == level_reg)
                     done_next = 1'b1;
                  else if (req_target > level_reg)
                     state_next = RAMP_UP;
                  else
                     state_next = RAMP_DN;
               end
            end
            RAMP_UP, RAMP_DN: begin
               // The first step waits only for the next boundary; later ones also serve the dwell.
               if (period_end) begin
                  if (first_reg || dwell_reg == DWELL_LAST) begin
                     level_next = level_step;
                     dwell_next = '0;
                     first_next = 1'b0;
                     if (level_step == target_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                     end
                  end else begin
                     dwell_next = dwell_reg + DWELL_INC;
                  end
               end
            end
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   pwm_level_enc u_enc (
      .level (level_next),
      .e     (e_next),
      .x     (x_next),
      .y     (y_next)
   );

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         phase_reg  <= 2'd0;
         dwell_reg  <= '0;
         first_reg  <= 1'b0;
         target_reg <= LVL_OFF;
         level_reg  <= LVL_OFF;
         done_reg   <= 1'b0;
         e_reg      <= 1'b0;
         x_reg      <= 1'b0;
         y_reg      <= 1'b0;
      end else begin
         state_reg  <= state_next;
         phase_reg  <= phase_reg + 2'd1;
         dwell_reg  <= dwell_next;
         first_reg  <= first_next;
         target_reg <= target_next;
         level_reg  <= level_next;
         done_reg   <= done_next;
         e_reg      <= e_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
      end
   end

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg == RAMP_UP) || (state_reg == RAMP_DN);
   assign done      = done_reg;
   assign level     = level_reg;
   assign E         = e_reg;
   assign X         = x_reg;
   assign Y         = y_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed and randomized checks for the PWM ramp sequencer with a 2-period dwell.
module tb_pwm_ramp_ctrl;

   localparam int DWELL = 2;
   localparam logic [8:0] RST_STAT = 9'b000_000_100;

   logic       Clk, reset, req_valid, fault;
   logic [2:0] req_level;
   logic       req_ready, E, X, Y, busy, done;
   logic [2:0] level;
   logic [1:0] ph;
   int         errors = 0;
   int         checks = 0;

   pwm_ramp_ctrl #(.DWELL_W(8), .DWELL(DWELL)) dut (
      .Clk       (Clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_level (req_level),
      .req_ready (req_ready),
      .fault     (fault),
      .E         (E),
      .X         (X),
      .Y         (Y),
      .level     (level),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Independent model of the PWM period phase.
   always @(posedge Clk or negedge reset)
      if (!reset) ph <= 2'd0;
      else        ph <= ph + 2'd1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [8:0] stat();
      return {E, X, Y, level, req_ready, busy, done};
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_phase(input logic [1:0] p);
      for (int i = 0; i < 4 && ph != p; i++) step();
   endtask

   task automatic send(input logic [2:0] lv);
      req_valid = 1'b1;
      req_level = lv;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; req_level = 3'd0; fault = 1'b0;
      #3;
      checks++;
      if (stat() !== RST_STAT) begin
         errors++; $display("FAIL reset_state: got %b want %b", stat(), RST_STAT);
      end
      #19 reset = 1'b1;
      step();
      checks++;
      if (stat() !== RST_STAT) begin
         errors++; $display("FAIL reset_release: got %b want %b", stat(), RST_STAT);
      end
      $display("reset: state %b", stat());
   endtask

   task automatic test_reset_mid_ramp();
      bit ok, seen;
      send(3'd4);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL midramp_accept: busy got %b want 1", busy);
      end
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (level == 3'd2) begin ok = 1'b1; break; end
         step();
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL midramp_reach: level got %0d want 2", level);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (stat() !== RST_STAT) begin
         errors++; $display("FAIL reset_midramp: got %b want %b", stat(), RST_STAT);
      end
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); if (done) seen = 1'b1; end
      #3 reset = 1'b1;
      for (int i = 0; i < 12; i++) begin step(); if (done || busy) seen = 1'b1; end
      checks++;
      if (seen) begin
         errors++; $display("FAIL reset_no_done: got done/busy activity want none");
      end
      checks++;
      if (stat() !== RST_STAT) begin
         errors++; $display("FAIL reset_after_release: got %b want %b", stat(), RST_STAT);
      end
      $display("reset mid-ramp: state %b", stat());
   endtask

   task automatic test_ramp_up();
      wait_phase(2'd1);
      send(3'd2);
      checks++;
      if ({busy, req_ready, level} !== {1'b1, 1'b0, 3'd0}) begin
         errors++; $display("FAIL rampup_accept: got busy=%b ready=%b level=%0d want 1 0 0", busy, req_ready, level);
      end
      step();
      checks++;
      if ({E, level} !== {1'b0, 3'd0}) begin
         errors++; $display("FAIL rampup_hold: got E=%b level=%0d want 0 0", E, level);
      end
      step();
      checks++;
      if ({E, X, Y, level, ph} !== {3'b100, 3'd1, 2'd0}) begin
         errors++; $display("FAIL rampup_step1: got EXY=%b%b%b level=%0d ph=%0d want 100 1 0", E, X, Y, level, ph);
      end
      for (int i = 0; i < 7; i++) step();
      checks++;
      if ({level, done} !== {3'd1, 1'b0}) begin
         errors++; $display("FAIL rampup_dwell: got level=%0d done=%b want 1 0", level, done);
      end
      step();
      checks++;
      if ({E, X, Y, level, done} !== {3'b101, 3'd2, 1'b1}) begin
         errors++; $display("FAIL rampup_step2: got EXY=%b%b%b level=%0d done=%b want 101 2 1", E, X, Y, level, done);
      end
      step();
      checks++;
      if ({done, busy, req_ready} !== 3'b001) begin
         errors++; $display("FAIL rampup_done_pulse: got done=%b busy=%b ready=%b want 0 0 1", done, busy, req_ready);
      end
      $display("ramp up: level %0d EXY %b%b%b", level, E, X, Y);
   endtask

   task automatic test_ramp_down_clamp();
      bit ok;
      int prev, last_t, nchg;
      send(3'd4);
      wait_done(40, ok);
      checks++;
      if (!ok || level !== 3'd4) begin
         errors++; $display("FAIL clamp_setup: got done=%b level=%0d want 1 4", ok, level);
      end
      send(3'd7);
      checks++;
      if ({level, busy, done, req_ready} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL clamp_done: got level=%0d busy=%b done=%b ready=%b want 4 0 1 1", level, busy, done, req_ready);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL clamp_pulse: done got %b want 0", done);
      end
      send(3'd0);
      prev = 4; last_t = -1; nchg = 0;
      for (int i = 1; i <= 80; i++) begin
         if (i > 1) step();
         if (int'(level) != prev) begin
            nchg++;
            checks++;
            if (int'(level) != prev - 1 || ph !== 2'd0 || (last_t >= 0 && i - last_t != 4 * DWELL)) begin
               errors++;
               $display("FAIL rampdn_step: got level=%0d ph=%0d gap=%0d want level=%0d ph=0 gap=%0d",
                        level, ph, i - last_t, prev - 1, 4 * DWELL);
            end
            last_t = i;
            prev = int'(level);
         end
         if (done) break;
      end
      checks++;
      if (nchg != 4 || {E, level, done} !== {1'b0, 3'd0, 1'b1}) begin
         errors++; $display("FAIL rampdn_end: got steps=%0d E=%b level=%0d done=%b want 4 0 0 1", nchg, E, level, done);
      end
      $display("ramp down: steps %0d level %0d", nchg, level);
   endtask

   task automatic test_handshake_gating();
      bit ok;
      req_valid = 1'b1;
      req_level = 3'd3;
      step();
      req_level = 3'd1;
      for (int i = 0; i < 80; i++) begin
         step();
         if (done) break;
         checks++;
         if (req_ready !== 1'b0) begin
            errors++; $display("FAIL gate_ready_low: req_ready got %b want 0", req_ready);
         end
      end
      checks++;
      if ({done, req_ready, level} !== {1'b1, 1'b1, 3'd3}) begin
         errors++; $display("FAIL gate_done: got done=%b ready=%b level=%0d want 1 1 3", done, req_ready, level);
      end
      step();
      req_valid = 1'b0;
      checks++;
      if ({busy, req_ready} !== 2'b10) begin
         errors++; $display("FAIL gate_accept_held: got busy=%b ready=%b want 1 0", busy, req_ready);
      end
      wait_done(60, ok);
      checks++;
      if (!ok || level !== 3'd1) begin
         errors++; $display("FAIL gate_held_target: got done=%b level=%0d want 1 1", ok, level);
      end
      $display("handshake gating: level %0d", level);
   endtask

   task automatic test_fault();
      bit ok, seen;
      send(3'd4);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (level == 3'd3) begin ok = 1'b1; break; end
         step();
      end
      wait_phase(2'd1);
      checks++;
      if (!ok || {level, busy} !== {3'd3, 1'b1}) begin
         errors++; $display("FAIL fault_setup: got level=%0d busy=%b want 3 1", level, busy);
      end
      fault = 1'b1; req_valid = 1'b1; req_level = 3'd2;
      step();
      checks++;
      if ({E, level, busy, req_ready, done} !== {1'b0, 3'd0, 3'b000}) begin
         errors++; $display("FAIL fault_entry: got E=%b level=%0d busy=%b ready=%b done=%b want 0 0 0 0 0", E, level, busy, req_ready, done);
      end
      step(); step();
      checks++;
      if ({level, req_ready, busy} !== {3'd0, 2'b00}) begin
         errors++; $display("FAIL fault_hold: got level=%0d ready=%b busy=%b want 0 0 0", level, req_ready, busy);
      end
      fault = 1'b0; req_valid = 1'b0;
      step();
      checks++;
      if (stat() !== RST_STAT) begin
         errors++; $display("FAIL fault_exit: got %b want %b", stat(), RST_STAT);
      end
      fault = 1'b1; req_valid = 1'b1; req_level = 3'd2;
      step();
      fault = 1'b0; req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (busy || done || level != 3'd0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL fault_priority: got request accepted want ignored");
      end
      $display("fault: state %b", stat());
   endtask

   task automatic test_random();
      int  fhold, prev, d;
      bit  fprev;
      fhold = 0;
      for (int i = 0; i < 10000; i++) begin
         if (fhold > 0) fhold--;
         else if ($urandom_range(0, 199) == 0) fhold = $urandom_range(1, 6);
         fault     = (fhold > 0);
         req_valid = ($urandom_range(0, 3) == 0);
         req_level = 3'($urandom_range(0, 7));
         fprev = fault;
         prev  = int'(level);
         step();
         if (int'(level) != prev) begin
            d = int'(level) - prev;
            checks++;
            if (!(fprev && level == 3'd0) && (ph !== 2'd0 || (d != 1 && d != -1))) begin
               errors++; $display("FAIL rand_step: got %0d->%0d ph=%0d want +-1 on phase 0", prev, level, ph);
            end
         end
         checks++;
         if (E !== (level != 3'd0) || level > 3'd4) begin
            errors++; $display("FAIL rand_enable: got E=%b level=%0d want E=(level!=0)", E, level);
         end
      end
      fault = 1'b0; req_valid = 1'b0;
      $display("random: final level %0d", level);
   endtask

   initial begin
      test_reset();
      test_reset_mid_ramp();
      test_ramp_up();
      test_ramp_down_clamp();
      test_handshake_gating();
      test_fault();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
